// File: rtl/mul_pipe_unit_if.sv
// mul_pipe_unit_if: request/result handshake and branch-bus signals of the multiply unit.
interface mul_pipe_unit_if #(
   parameter int XLEN      = 32,
   parameter int MASK_W    = 4,
   parameter int PAYLOAD_W = 8
);
   localparam int TW = MASK_W > 1 ? $clog2(MASK_W) : 1;
   logic                 brb_broadcast;
   logic [TW-1:0]        brb_tag;
   logic                 brb_clean;
   logic                 brb_kill;
   logic                 in_valid;
   logic                 in_ready;
   logic [XLEN-1:0]      in_a;
   logic [XLEN-1:0]      in_b;
   logic [1:0]           in_op;
   logic [MASK_W-1:0]    in_mask;
   logic [PAYLOAD_W-1:0] in_payload;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_result;
   logic [MASK_W-1:0]    out_mask;
   logic [PAYLOAD_W-1:0] out_payload;
   logic                 busy;
   modport slave (
      input  brb_broadcast, brb_tag, brb_clean, brb_kill,
      input  in_valid, in_a, in_b, in_op, in_mask, in_payload, out_ready,
      output in_ready, out_valid, out_result, out_mask, out_payload, busy
   );
   modport master (
      output brb_broadcast, brb_tag, brb_clean, brb_kill,
      output in_valid, in_a, in_b, in_op, in_mask, in_payload, out_ready,
      input  in_ready, out_valid, out_result, out_mask, out_payload, busy
   );
endinterface

// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: pipelined RV M-extension multiplier with bubble collapse and branch clean/kill.
module mul_pipe_unit #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 4,
   parameter int MASK_W    = 4,
   parameter int PAYLOAD_W = 8
) (
   input logic          clk,
   input logic          rst,
   mul_pipe_unit_if.slave io
);
   logic                 kill;
   logic [MASK_W-1:0]    clr;
   logic [2*XLEN-1:0]    a_x, b_x, prod;
   logic [XLEN-1:0]      res_in;
   logic [DEPTH-1:0]     v_q, v_d, adv, ld, live, s_v;
   logic [XLEN-1:0]      res_q  [DEPTH];
   logic [XLEN-1:0]      s_res  [DEPTH];
   logic [MASK_W-1:0]    mask_q [DEPTH];
   logic [MASK_W-1:0]    m_d    [DEPTH];
   logic [MASK_W-1:0]    s_mask [DEPTH];
   logic [PAYLOAD_W-1:0] pay_q  [DEPTH];
   logic [PAYLOAD_W-1:0] s_pay  [DEPTH];

   assign kill = io.brb_broadcast & io.brb_kill & ~io.brb_clean;
   assign clr  = (io.brb_broadcast & io.brb_clean) ? MASK_W'(1) << io.brb_tag : '0;

   // Operands widened to 2*XLEN: the low 2*XLEN bits of the wrapped product are exact for every signedness mix.
   assign a_x    = {{XLEN{(io.in_op != 2'b11) & io.in_a[XLEN-1]}}, io.in_a};
   assign b_x    = {{XLEN{~io.in_op[1] & io.in_b[XLEN-1]}}, io.in_b};
   assign prod   = a_x * b_x;
   assign res_in = (io.in_op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   for (genvar k = 0; k < DEPTH; k++) begin : g_st
      if (k == 0) begin : g_head
         assign s_v[k]    = io.in_valid;
         assign s_res[k]  = res_in;
         assign s_mask[k] = io.in_mask;
         assign s_pay[k]  = io.in_payload;
      end else begin : g_body
         assign s_v[k]    = v_q[k-1];
         assign s_res[k]  = res_q[k-1];
         assign s_mask[k] = mask_q[k-1];
         assign s_pay[k]  = pay_q[k-1];
      end
      // A stage moves unless it and every stage downstream are full while the output is stalled.
      assign adv[k]  = ~(&v_q[DEPTH-1:k]) | io.out_ready;
      assign ld[k]   = adv[k] & s_v[k];
      assign m_d[k]  = (adv[k] ? s_mask[k] : mask_q[k]) & ~clr;
      assign v_d[k]  = (adv[k] ? s_v[k] : v_q[k]) &
                       ~(kill & (adv[k] ? s_mask[k][io.brb_tag] : mask_q[k][io.brb_tag]));
      assign live[k] = v_q[k] & ~(kill & mask_q[k][io.brb_tag]);
   end

   assign io.in_ready    = adv[0];
   assign io.out_valid   = live[DEPTH-1];
   assign io.out_result  = res_q[DEPTH-1];
   assign io.out_mask    = mask_q[DEPTH-1];
   assign io.out_payload = pay_q[DEPTH-1];
   assign io.busy        = |live;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            res_q[i]  <= '0;
            mask_q[i] <= '0;
            pay_q[i]  <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int i = 0; i < DEPTH; i++) begin
            mask_q[i] <= m_d[i];
            if (ld[i]) begin
               res_q[i] <= s_res[i];
               pay_q[i] <= s_pay[i];
            end
         end
      end
   end
endmodule

// File: tb/tb_mul_pipe_unit.sv
// tb_mul_pipe_unit: vector table, directed stall/kill/clean/reset sequences and a random sweep,
// all results checked through an in-order scoreboard.
module tb_mul_pipe_unit;
   localparam int XLEN = 32, DEPTH = 4, MASK_W = 4, PAYLOAD_W = 8;

   typedef struct { logic [31:0] a, b; logic [1:0] op; logic [31:0] exp; } vec_t;
   typedef struct { logic [31:0] res; logic [3:0] mask; logic [7:0] pay; } sb_t;

   logic        clk = 0, rst = 1;
   int          tests = 0, fails = 0, pops = 0;
   logic [31:0] pend_exp = '0;
   sb_t         q[$];
   sb_t         e_mon;
   vec_t        tbl[11];

   mul_pipe_unit_if #(.XLEN(XLEN), .MASK_W(MASK_W), .PAYLOAD_W(PAYLOAD_W)) io();
   mul_pipe_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .MASK_W(MASK_W), .PAYLOAD_W(PAYLOAD_W))
      dut (.clk(clk), .rst(rst), .io(io));

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      p  = op == 2'b11 ? ua * ub : op == 2'b10 ? sa * ub : sa * sb;
      return op == 2'b00 ? p[31:0] : p[63:32];
   endfunction

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Scoreboard mirrors the in-flight set: pop on handoff, push on accept, then apply the branch broadcast.
   always @(negedge clk) begin
      if (rst) q.delete();
      else begin
         if (io.out_valid && io.out_ready) begin
            pops++;
            if (q.size() == 0) chk("unexpected_out", 64'({io.out_result, io.out_payload}), 64'hdead);
            else begin
               e_mon = q.pop_front();
               chk("out", 64'({io.out_result, io.out_mask, io.out_payload}), 64'({e_mon.res, e_mon.mask, e_mon.pay}));
            end
         end
         if (io.in_valid && io.in_ready) q.push_back('{res: pend_exp, mask: io.in_mask, pay: io.in_payload});
         if (io.brb_broadcast && io.brb_clean) begin
            foreach (q[i]) q[i].mask[io.brb_tag] = 1'b0;
         end else if (io.brb_broadcast && io.brb_kill) begin
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].mask[io.brb_tag]) q.delete(i);
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [3:0] m, input logic [7:0] p, input logic [31:0] exp);
      io.in_a = a; io.in_b = b; io.in_op = op; io.in_mask = m; io.in_payload = p;
      pend_exp = exp; io.in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (io.in_ready) break;
         if (n == 199) chk("send_timeout", 64'(io.in_ready), 64'd1);
      end
      @(posedge clk); #1;
      io.in_valid = 1'b0;
   endtask

   task automatic set_in(input logic [3:0] m, input logic [7:0] p);
      io.in_a = $urandom; io.in_b = $urandom; io.in_op = 2'($urandom_range(0, 3));
      io.in_mask = m; io.in_payload = p;
      pend_exp = ref_mul(io.in_a, io.in_b, io.in_op);
   endtask

   task automatic wait_drain(input string name);
      for (int n = 0; n < 100; n++) begin
         @(posedge clk); #1;
         if (!io.busy && q.size() == 0) break;
      end
      chk(name, 64'({io.busy, 32'(q.size())}), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n, acc, p0;
      logic rdy_all;
      tbl[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001};
      tbl[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h00000000};
      tbl[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF};
      tbl[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE};
      tbl[4]  = '{32'h80000000, 32'h80000000, 2'b01, 32'h40000000};
      tbl[5]  = '{32'h80000000, 32'h80000000, 2'b11, 32'h40000000};
      tbl[6]  = '{32'h80000000, 32'h80000000, 2'b10, 32'hC0000000};
      tbl[7]  = '{32'hFFFFFFFD, 32'h00000007, 2'b00, 32'hFFFFFFEB};
      tbl[8]  = '{32'hFFFFFFFD, 32'h00000007, 2'b01, 32'hFFFFFFFF};
      tbl[9]  = '{32'h12345678, 32'h00000010, 2'b11, 32'h00000001};
      tbl[10] = '{32'h12345678, 32'h00000010, 2'b00, 32'h23456780};
      io.brb_broadcast = 0; io.brb_tag = 0; io.brb_clean = 0; io.brb_kill = 0;
      io.in_valid = 0; io.in_a = 0; io.in_b = 0; io.in_op = 0; io.in_mask = 0; io.in_payload = 0;
      io.out_ready = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_out_valid", 64'(io.out_valid), 64'd0);
      chk("rst_busy", 64'(io.busy), 64'd0);
      chk("rst_in_ready", 64'(io.in_ready), 64'd1);
      chk("rst_out_bus", 64'({io.out_result, io.out_mask, io.out_payload}), 64'd0);
      @(posedge clk); #1;

      send(32'd3, 32'd5, 2'b00, 4'b0000, 8'h01, 32'd15);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (io.out_valid) break;
         n++;
      end
      chk("latency", 64'(n), 64'(DEPTH));
      wait_drain("drain_latency");

      foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].op, 4'b0000, 8'(i), tbl[i].exp);
      wait_drain("drain_table");

      io.out_ready = 0; acc = 0;
      set_in(4'b0000, 8'h40);
      io.in_valid = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!io.in_ready) break;
         acc++;
         @(posedge clk); #1;
         set_in(4'b0000, 8'(8'h40 + acc));
      end
      chk("fill_accepts", 64'(acc), 64'(DEPTH));
      @(posedge clk); #1;
      io.out_ready = 1; rdy_all = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rdy_all &= io.in_ready;
         @(posedge clk); #1;
         set_in(4'b0000, 8'(8'h50 + i));
      end
      io.in_valid = 0;
      chk("passthru_in_ready", 64'(rdy_all), 64'd1);
      wait_drain("drain_fill");

      io.out_ready = 0;
      send(32'd2, 32'd3, 2'b00, 4'b0001, 8'h11, 32'd6);
      send(32'd4, 32'd5, 2'b00, 4'b0010, 8'h22, 32'd20);
      send(32'd6, 32'd7, 2'b00, 4'b0001, 8'h33, 32'd42);
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      chk("kill_pre", 64'({io.out_valid, io.out_payload}), 64'({1'b1, 8'h11}));
      @(posedge clk); #1;
      io.brb_broadcast = 1; io.brb_kill = 1; io.brb_tag = 2'd0;
      @(negedge clk);
      chk("kill_same_cycle", 64'(io.out_valid), 64'd0);
      p0 = pops;
      @(posedge clk); #1;
      io.brb_broadcast = 0; io.brb_kill = 0; io.out_ready = 1;
      wait_drain("drain_kill");
      chk("kill_delivered", 64'(pops - p0), 64'd1);

      io.out_ready = 0;
      send(32'h1234, 32'h10, 2'b00, 4'b0011, 8'h5A, 32'h12340);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (io.out_valid) break;
      end
      @(posedge clk); #1;
      io.brb_broadcast = 1; io.brb_clean = 1; io.brb_tag = 2'd1;
      @(negedge clk);
      chk("clean_mask_registered", 64'(io.out_mask), 64'(4'b0011));
      @(posedge clk); #1;
      io.brb_broadcast = 0; io.brb_clean = 0;
      @(negedge clk);
      chk("clean_mask", 64'(io.out_mask), 64'(4'b0001));
      chk("clean_hold", 64'({io.out_valid, io.out_result, io.out_payload}), 64'({1'b1, 32'h12340, 8'h5A}));
      @(posedge clk); #1;
      io.out_ready = 1;
      wait_drain("drain_clean");

      p0 = pops;
      send(32'd9, 32'd9, 2'b00, 4'b0000, 8'h71, 32'd81);
      send(32'd8, 32'd8, 2'b00, 4'b0000, 8'h72, 32'd64);
      send(32'd7, 32'd7, 2'b00, 4'b0000, 8'h73, 32'd49);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rst_mid", 64'({io.out_valid, io.busy}), 64'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("rst_mid_no_output", 64'(pops - p0), 64'd0);

      for (int i = 0; i < 3000; i++) begin
         io.in_valid = $urandom_range(0, 3) != 0;
         set_in($urandom_range(0, 1) ? 4'($urandom) : 4'b0000, 8'($urandom));
         io.out_ready = $urandom_range(0, 3) != 0;
         io.brb_broadcast = $urandom_range(0, 7) == 0;
         io.brb_tag = 2'($urandom);
         io.brb_clean = $urandom_range(0, 1) == 1;
         io.brb_kill = $urandom_range(0, 1) == 1;
         @(posedge clk); #1;
      end
      io.in_valid = 0; io.brb_broadcast = 0; io.brb_clean = 0; io.brb_kill = 0; io.out_ready = 1;
      wait_drain("drain_random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mul_pipe_unit.md
# mul_pipe_unit

Parametrised, fully pipelined RV32M/RV64M multiply functional unit for the backend execute stage. It accepts one MUL/MULH/MULHSU/MULHU per cycle through a valid/ready handshake and carries a branch mask and an opaque payload (ROB index, destination tag) alongside each operation. Pipeline bubbles collapse under output backpressure. Branch-bus clean/kill broadcasts are applied to every in-flight entry every cycle, whether or not the pipe is stalled. The block sits between the multiply reservation station and the CDB arbiter.

## Interface
- XLEN, 32: operand/result width (32 or 64).
- DEPTH, 4: pipeline stages, ≥1; equals the unloaded latency in cycles.
- MASK_W, 4: branch mask width (number of in-flight branch tags).
- PAYLOAD_W, 8: opaque payload width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- brb_broadcast  in  1  branch resolution broadcast valid.
- brb_tag  in  $clog2(MASK_W)  resolved branch tag.
- brb_clean  in  1  branch correctly predicted: clear that mask bit.
- brb_kill  in  1  branch mispredicted: squash ops dependent on the tag.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_a, in_b  in  XLEN  rs1, rs2 operands.
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_mask  in  MASK_W  branch mask of the request.
- in_payload  in  PAYLOAD_W  carried unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_result  out  XLEN  selected product half.
- out_mask  out  MASK_W  branch mask of the result, registered.
- out_payload  out  PAYLOAD_W  payload of the result.
- busy  out  1  any stage holds a valid entry.

## Operation
- Arithmetic: a is sign-extended to XLEN+1 bits for MUL/MULH/MULHSU and zero-extended for MULHU. b is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU. The full signed product must be exact.
- Result selection: MUL returns product[XLEN-1:0]. The other three ops return product[2·XLEN-1:XLEN].
- Implementation of the multiply is free: partial-product slices spread across stages or a retimed array are both acceptable. Each stage register holds valid, op, mask, payload and its partial data.
- Stages are numbered 1..DEPTH. Stage DEPTH drives the out_* ports.
- Stage advance rule: stage k advances when it is empty, or when stage k+1 is empty or advancing. Stage DEPTH advances when it is empty or when out_valid & out_ready.
- in_ready equals stage 1's advance condition. It is combinational from out_ready and the stage valids, and never depends on in_valid.
- Clean (brb_broadcast & brb_clean) clears mask bit brb_tag in every stage, including an entry being accepted or moved in the same cycle. It is applied to stalled stages too.
- Kill (brb_broadcast & brb_kill & ~brb_clean) invalidates every entry whose mask bit brb_tag is set, in stalled and moving stages alike. An accepting request with in_mask[brb_tag]=1 is dropped, but in_ready is still reported normally.
- Same-cycle kill suppresses out_valid combinationally, so a killed result is never handed off.
- If brb_clean and brb_kill are both high, clean wins.
- out_mask is the registered mask. Consumers apply any same-cycle clean themselves.
- busy is the OR of all stage valids, after kill.

## Timing
- Reset: all stage valids and data are 0. out_valid=0, out_result=0, out_mask=0, out_payload=0, busy=0. in_ready=1 from the first cycle after reset.
- Latency: a request accepted in cycle c gives out_valid in cycle c+DEPTH when unstalled.
- Throughput: 1 op/cycle with out_ready held high.
- Stall: while out_valid & ~out_ready, out_* holds stable except for mask clean and kill. Upstream stages keep filling bubbles. in_ready falls only when all DEPTH stages are full and the output is not draining.
- Full-pipe pass-through: when full, in_ready = out_ready, and same-cycle drain plus accept is allowed.
- Reset mid-operation: all in-flight entries are discarded. No output appears afterwards.
- Ordering: results emerge in acceptance order, minus killed entries.

## Test plan
- XLEN=32, a=b=0xFFFFFFFF, ops 00/01/10/11 back-to-back -> results 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE, on consecutive cycles starting 4 cycles after the first accept.
- a=0x80000000, b=0x80000000, MULH -> 0x40000000. MULHU -> 0x40000000. MULHSU -> 0xC0000000. Also run a random sweep of 10k ops against a reference model at XLEN=32 and XLEN=64.
- Fill the pipe with out_ready=0 -> in_ready falls after exactly 4 accepts. Raise out_ready and keep in_valid high -> one result per cycle, in_ready=1 throughout, no op lost or duplicated.
- Stall with ops of masks 0001 (output stage), 0010, 0001 in flight, then kill tag 0 -> out_valid drops that same cycle. Only the 0010 op is delivered, and busy clears after it drains.
- Stalled op with mask 0011, clean tag 1 -> out_mask=0001 next cycle. Result and payload are unchanged.
- Assert rst with 3 ops in flight -> out_valid=0 and busy=0 the next cycle, and no result is ever delivered for those ops.
